imm_extender_pipe: RTL and testbench
====================================

IMM_EXTENDER_PIPE -- requirements
Module: imm_extender_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output data width.
REQ-002 SHALL have parameter IMMDATA_WIDTH, default 21, immediate field width; legal range 1..DATA_WIDTH, with an elaboration-time error otherwise.
REQ-003 SHALL have parameter OVFCNT_WIDTH, default 16, overflow counter width.
REQ-004 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RSTN  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port IVALID  in  1  input request valid.
REQ-007 SHALL have port IREADY  out  1  block can accept a request.
REQ-008 SHALL have port IMMDATA  in  IMMDATA_WIDTH  immediate field.
REQ-009 SHALL have port MODE  in  2  extension mode: 0 ZERO, 1 SIGN, 2 UPPER, 3 SHIFT.
REQ-010 SHALL have port SHAMT  in  clog2(DATA_WIDTH)  left-shift amount, used in SHIFT mode only.
REQ-011 SHALL have port OVALID  out  1  result valid.
REQ-012 SHALL have port OREADY  in  1  consumer accepts result.
REQ-013 SHALL have port ODATA  out  DATA_WIDTH  extended result.
REQ-014 SHALL have port OVF  out  1  result overflowed, qualified by OVALID.
REQ-015 SHALL have port CLR  in  1  synchronous clear of OVFCNT.
REQ-016 SHALL have port OVFCNT  out  OVFCNT_WIDTH  saturating count of accepted requests with OVF=1.

Function
REQ-017 ZERO SHALL produce {zeros, IMMDATA}.
REQ-018 SIGN SHALL replicate IMMDATA[IMMDATA_WIDTH-1] into all upper bits.
REQ-019 UPPER SHALL place IMMDATA in ODATA[DATA_WIDTH-1 -: IMMDATA_WIDTH] with lower bits zero.
REQ-020 SHIFT SHALL sign-extend, then shift left by SHAMT; bits shifted out are discarded.
REQ-021 OVF SHALL be 1 only in SHIFT mode, when the shifted-out bits and the result MSB are not all equal; it SHALL be 0 in every other mode.
REQ-022 A transfer SHALL occur on IVALID&&IREADY; inputs are sampled only then.
REQ-023 Results SHALL be held in a 2-entry in-order FIFO; occupancy counter range 0..2.
REQ-024 IREADY SHALL be 1 when occupancy<2, decoded from registered occupancy only, with no combinational path from OREADY.
REQ-025 Latency: an accepted request SHALL appear on ODATA/OVF with OVALID=1 on the next cycle when the FIFO was empty.
REQ-026 OVALID SHALL be 1 when occupancy>0; ODATA/OVF SHALL show the head entry and stay stable while OVALID&&!OREADY.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order, including at occupancy 1.
REQ-028 Pop on OVALID=0 and push on IREADY=0 SHALL be ignored.
REQ-029 OVFCNT SHALL increment by 1 per accepted request whose computed OVF=1, and SHALL saturate at all-ones.
REQ-030 CLR SHALL zero OVFCNT next cycle and SHALL take priority over a simultaneous increment.
REQ-031 Write and read pointers SHALL wrap modulo 2.

Reset
REQ-032 While RSTN=0 at a clock edge, occupancy, pointers and OVFCNT SHALL become 0, so that OVALID=0 and IREADY=1 from the next cycle.
REQ-033 ODATA and OVF SHALL read 0 after reset until the first push.
REQ-034 Reset mid-operation SHALL discard all buffered entries; a request presented during the reset cycle SHALL NOT be accepted.

Structure
REQ-035 The mode encodings (ZERO/SIGN/UPPER/SHIFT) SHALL be constants in the shared processor package.
REQ-036 The combinational extend/shift/overflow logic SHALL be one sub-module, imm_extend_core; FIFO, handshake and counter SHALL be in imm_extender_pipe.

Verification
Scenarios use the defaults (DATA_WIDTH 32, IMMDATA_WIDTH 21) with OREADY=1 unless stated.
REQ-037 Scenario 1: ZERO, IMMDATA 0x1FFFFF -> next cycle ODATA 0x001FFFFF, OVF 0.
REQ-038 Scenario 2: SIGN, IMMDATA 0x100000 -> ODATA 0xFFF00000. UPPER, IMMDATA 0x000001 -> ODATA 0x00000800.
REQ-039 Scenario 3: SHIFT, IMMDATA 0x000003, SHAMT 31 -> ODATA 0x80000000, OVF 1, OVFCNT +1. SHIFT, IMMDATA 0x1FFFFF, SHAMT 4 -> ODATA 0xFFFFFFF0, OVF 0.
REQ-040 Scenario 4: OREADY=0, three back-to-back requests A, B, C -> A and B accepted, IREADY=0, C held. Raise OREADY -> A, B, C delivered in order, with no loss or duplication.
REQ-041 Scenario 5: RSTN=0 for one cycle with 2 entries buffered and OVFCNT=5 -> next cycle OVALID 0, IREADY 1, OVFCNT 0.
REQ-042 Scenario 6: OVFCNT_WIDTH=2, four overflowing requests -> OVFCNT sticks at 3. CLR together with an overflowing request -> OVFCNT 0.

Source files
------------

// File: rtl/imm_extender_pipe_pkg.sv
// Shared encodings and sizing constants for the immediate-extension pipeline.
package imm_extender_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_SIGN  = 2'd1,
        MODE_UPPER = 2'd2,
        MODE_SHIFT = 2'd3
    } imm_mode_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_extender_pipe_core.sv
// Purely combinational immediate extension: zero/sign/upper placement and
// sign-extend-then-shift with overflow detection.
module imm_extend_core
    import imm_extender_pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int IMMDATA_WIDTH = 21,
    parameter int SHAMT_WIDTH   = $clog2(DATA_WIDTH)
) (
    input  logic [IMMDATA_WIDTH-1:0] imm,
    input  imm_mode_e                mode,
    input  logic [SHAMT_WIDTH-1:0]   shamt,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     ovf
);

    logic [DATA_WIDTH-1:0]   zext;
    logic [DATA_WIDTH-1:0]   sext;
    logic [DATA_WIDTH-1:0]   upper;
    logic [2*DATA_WIDTH-1:0] wide;
    logic [DATA_WIDTH:0]     shifted_top;

    assign zext  = DATA_WIDTH'(imm);
    // Shifting the fill by IMMDATA_WIDTH also covers IMMDATA_WIDTH == DATA_WIDTH (fill becomes 0).
    assign sext  = zext | ({DATA_WIDTH{imm[IMMDATA_WIDTH-1]}} << IMMDATA_WIDTH);
    assign upper = zext << (DATA_WIDTH - IMMDATA_WIDTH);

    // The upper half holds the shifted-out bits plus further sign copies, so the
    // result is exact only when that half and the result MSB all agree.
    assign wide        = {{DATA_WIDTH{sext[DATA_WIDTH-1]}}, sext} << shamt;
    assign shifted_top = wide[2*DATA_WIDTH-1:DATA_WIDTH-1];
    assign ovf         = (mode == MODE_SHIFT) && !((&shifted_top) || !(|shifted_top));

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves data unassigned (no latch).
        data = zext;
        case (mode)
            MODE_ZERO:  data = zext;
            MODE_SIGN:  data = sext;
            MODE_UPPER: data = upper;
            MODE_SHIFT: data = wide[DATA_WIDTH-1:0];
            default:    data = zext;
        endcase
    end

endmodule

// File: rtl/imm_extender_pipe.sv
// Immediate extender with valid/ready handshake, 2-entry result FIFO and a
// saturating overflow counter.
module imm_extender_pipe
    import imm_extender_pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int IMMDATA_WIDTH = 21,
    parameter int OVFCNT_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          IVALID,
    output logic                          IREADY,
    input  logic [IMMDATA_WIDTH-1:0]      IMMDATA,
    input  logic [1:0]                    MODE,
    input  logic [$clog2(DATA_WIDTH)-1:0] SHAMT,
    output logic                          OVALID,
    input  logic                          OREADY,
    output logic [DATA_WIDTH-1:0]         ODATA,
    output logic                          OVF,
    input  logic                          CLR,
    output logic [OVFCNT_WIDTH-1:0]       OVFCNT
);

    if (IMMDATA_WIDTH < 1 || IMMDATA_WIDTH > DATA_WIDTH) begin : g_bad_width
        $error("imm_extender_pipe: IMMDATA_WIDTH must be in 1..DATA_WIDTH");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  ovf;
    } entry_t;

    entry_t                  mem [FIFO_DEPTH];
    entry_t                  new_entry;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic [OVFCNT_WIDTH-1:0] ovf_count;
    logic                    push;
    logic                    pop;

    imm_extend_core #(
        .DATA_WIDTH    (DATA_WIDTH),
        .IMMDATA_WIDTH (IMMDATA_WIDTH),
        .SHAMT_WIDTH   ($clog2(DATA_WIDTH))
    ) u_core (
        .imm   (IMMDATA),
        .mode  (imm_mode_e'(MODE)),
        .shamt (SHAMT),
        .data  (new_entry.data),
        .ovf   (new_entry.ovf)
    );

    // Handshake flags come from registered occupancy only; OREADY never reaches IREADY.
    assign IREADY = (count != 2'(FIFO_DEPTH));
    assign OVALID = (count != 2'd0);
    assign push   = IVALID && IREADY;
    assign pop    = OVALID && OREADY;

    assign ODATA  = mem[rd_ptr].data;
    assign OVF    = mem[rd_ptr].ovf;
    assign OVFCNT = ovf_count;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            ovf_count <= '0;
            // NOTE: the two storage entries are reset so ODATA/OVF read 0 until the first push.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (CLR) begin
                ovf_count <= '0;
            end else if (push && new_entry.ovf && !(&ovf_count)) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// pops and compares on every output handshake.
module tb_imm_extender_pipe;
    import imm_extender_pipe_pkg::*;

    localparam int DW = 32;
    localparam int IW = 21;
    localparam int SW = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ivalid;
    logic          oready;
    logic          clr;
    logic [IW-1:0] imm;
    logic [1:0]    mode;
    logic [SW-1:0] shamt;

    logic          iready, ovalid, ovf;
    logic [DW-1:0] odata;
    logic [15:0]   ovfcnt;
    logic          iready2, ovalid2, ovf2;
    logic [DW-1:0] odata2;
    logic [1:0]    ovfcnt2;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    imm_extender_pipe #(.DATA_WIDTH(DW), .IMMDATA_WIDTH(IW), .OVFCNT_WIDTH(16)) u_dut (
        .CLK(clk), .RSTN(rstn), .IVALID(ivalid), .IREADY(iready), .IMMDATA(imm),
        .MODE(mode), .SHAMT(shamt), .OVALID(ovalid), .OREADY(oready), .ODATA(odata),
        .OVF(ovf), .CLR(clr), .OVFCNT(ovfcnt)
    );

    imm_extender_pipe #(.DATA_WIDTH(DW), .IMMDATA_WIDTH(IW), .OVFCNT_WIDTH(2)) u_dut_sat (
        .CLK(clk), .RSTN(rstn), .IVALID(ivalid), .IREADY(iready2), .IMMDATA(imm),
        .MODE(mode), .SHAMT(shamt), .OVALID(ovalid2), .OREADY(oready), .ODATA(odata2),
        .OVF(ovf2), .CLR(clr), .OVFCNT(ovfcnt2)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (ovalid === 1'b1 && oready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output actual=%h expected=none", odata);
            end else begin
                mon_e = exp_q.pop_front();
                check("odata", odata, mon_e.data);
                check("ovf", DW'(ovf), DW'(mon_e.ovf));
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [IW-1:0] im, input logic [SW-1:0] sh,
                        input logic [DW-1:0] ed, input logic eo);
        int waited = 0;
        ivalid = 1'b1;
        mode   = m;
        imm    = im;
        shamt  = sh;
        @(negedge clk);
        while (iready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (iready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout actual=iready_low expected=iready_high");
        end else begin
            exp_q.push_back(exp_t'{data: ed, ovf: eo});
        end
        @(posedge clk);
        #1;
        ivalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_empty", DW'(exp_q.size()), 0);
        @(negedge clk);
        check("ovalid_idle", DW'(ovalid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn   = 1'b0;
        ivalid = 1'b0;
        oready = 1'b1;
        clr    = 1'b0;
        imm    = '0;
        mode   = 2'd0;
        shamt  = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ovalid", DW'(ovalid), 0);
        check("rst_iready", DW'(iready), 1);
        check("rst_odata", odata, 0);
        check("rst_ovf", DW'(ovf), 0);
        check("rst_ovfcnt", DW'(ovfcnt), 0);
        check("rst_ovfcnt_sat", DW'(ovfcnt2), 0);

        // Scenario 1 with single-cycle latency from an empty FIFO
        @(posedge clk);
        #1;
        send(MODE_ZERO, 21'h1FFFFF, 5'd0, 32'h001FFFFF, 1'b0);
        @(negedge clk);
        check("latency_ovalid", DW'(ovalid), 1);
        drain();

        // Scenarios 2 and 3 back-to-back: push and pop together at occupancy 1
        @(posedge clk);
        #1;
        send(MODE_SIGN,  21'h100000, 5'd0,  32'hFFF00000, 1'b0);
        send(MODE_SIGN,  21'h0FFFFF, 5'd9,  32'h000FFFFF, 1'b0);
        send(MODE_UPPER, 21'h000001, 5'd0,  32'h00000800, 1'b0);
        send(MODE_UPPER, 21'h1FFFFF, 5'd31, 32'hFFFFF800, 1'b0);
        send(MODE_ZERO,  21'h000005, 5'd7,  32'h00000005, 1'b0);
        send(MODE_SHIFT, 21'h000003, 5'd31, 32'h80000000, 1'b1);
        send(MODE_SHIFT, 21'h1FFFFF, 5'd4,  32'hFFFFFFF0, 1'b0);
        send(MODE_SHIFT, 21'h000001, 5'd31, 32'h80000000, 1'b1);
        send(MODE_SHIFT, 21'h100000, 5'd0,  32'hFFF00000, 1'b0);
        send(MODE_SHIFT, 21'h040000, 5'd12, 32'h40000000, 1'b0);
        send(MODE_SHIFT, 21'h040000, 5'd13, 32'h80000000, 1'b1);
        drain();
        check("ovfcnt_after_s3", DW'(ovfcnt), 3);
        check("ovfcnt_sat_after_s3", DW'(ovfcnt2), 3);

        // Scenario 4: stall with a full FIFO, held request, then in-order drain
        @(posedge clk);
        #1;
        oready = 1'b0;
        send(MODE_ZERO, 21'h000AAA, 5'd0, 32'h00000AAA, 1'b0);
        send(MODE_SIGN, 21'h1FFFFE, 5'd0, 32'hFFFFFFFE, 1'b0);
        ivalid = 1'b1;
        mode   = MODE_UPPER;
        imm    = 21'h000003;
        shamt  = 5'd0;
        repeat (3) begin
            @(negedge clk);
            check("full_iready", DW'(iready), 0);
            check("stall_ovalid", DW'(ovalid), 1);
            check("stall_odata", odata, 32'h00000AAA);
        end
        @(posedge clk);
        #1;
        oready = 1'b1;
        send(MODE_UPPER, 21'h000003, 5'd0, 32'h00001800, 1'b0);
        drain();

        // Scenario 5: reset with two buffered entries and OVFCNT=5
        @(posedge clk);
        #1;
        oready = 1'b0;
        send(MODE_SHIFT, 21'h000003, 5'd31, 32'h80000000, 1'b1);
        send(MODE_SHIFT, 21'h0FFFFF, 5'd12, 32'hFFFFF000, 1'b1);
        @(negedge clk);
        check("pre_rst_ovfcnt", DW'(ovfcnt), 5);
        check("pre_rst_iready", DW'(iready), 0);
        @(posedge clk);
        #1;
        rstn   = 1'b0;
        ivalid = 1'b1;
        mode   = MODE_ZERO;
        imm    = 21'h012345;
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        ivalid = 1'b0;
        @(negedge clk);
        check("mid_rst_ovalid", DW'(ovalid), 0);
        check("mid_rst_iready", DW'(iready), 1);
        check("mid_rst_ovfcnt", DW'(ovfcnt), 0);
        check("mid_rst_odata", odata, 0);
        check("mid_rst_ovf", DW'(ovf), 0);
        check("mid_rst_ovfcnt_sat", DW'(ovfcnt2), 0);

        // Scenario 6: saturation of the 2-bit counter, then CLR beats an increment
        @(posedge clk);
        #1;
        oready = 1'b1;
        send(MODE_SHIFT, 21'h000003, 5'd31, 32'h80000000, 1'b1);
        send(MODE_SHIFT, 21'h0FFFFF, 5'd12, 32'hFFFFF000, 1'b1);
        send(MODE_SHIFT, 21'h100000, 5'd12, 32'h00000000, 1'b1);
        send(MODE_SHIFT, 21'h000001, 5'd31, 32'h80000000, 1'b1);
        drain();
        check("sat_ovfcnt", DW'(ovfcnt2), 3);
        check("wide_ovfcnt", DW'(ovfcnt), 4);
        @(posedge clk);
        #1;
        clr = 1'b1;
        send(MODE_SHIFT, 21'h000003, 5'd31, 32'h80000000, 1'b1);
        clr = 1'b0;
        @(negedge clk);
        check("clr_ovfcnt_sat", DW'(ovfcnt2), 0);
        check("clr_ovfcnt", DW'(ovfcnt), 0);
        drain();
        @(posedge clk);
        #1;
        send(MODE_SHIFT, 21'h040000, 5'd13, 32'h80000000, 1'b1);
        drain();
        check("post_clr_ovfcnt_sat", DW'(ovfcnt2), 1);
        check("post_clr_ovfcnt", DW'(ovfcnt), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
